// File: rtl/piso_bit_serializer.sv
// piso_bit_serializer
// Parallel-in / serial-out feeder for the serial sequence-detector stage.
// Words arrive over a valid/ready handshake and leave on bit_out, MSB first,
// one bit per clock. Back-to-back words stream with no idle bubble.
// Optional feature macro: PARITY_EN appends an even-parity bit after the LSB.
//
// Handshake: a word is taken on a rising clk edge where din_valid and
// din_ready are both high. din_valid may be raised at any time. din is only
// sampled on that accepting edge. din_ready is high in IDLE and in the final
// bit cycle of a frame, so a waiting word is loaded with no gap. din_ready is
// forced low while rst is high, so nothing can be loaded during reset.
module piso_bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // FSM state is kept in a named enum signal so checkers can bind to it.
  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             fs_q;
  logic             last_bit;
  logic             ready_slot;
  logic             accept;
`ifdef PARITY_EN
  logic             par_q;
`endif

  assign last_bit = (state == SHIFT) && (cnt == '0);

  // Handshake slot: IDLE plus the last cycle of the frame currently on the wire.
  always_comb begin
    ready_slot = 1'b0;
`ifdef PARITY_EN
    ready_slot = (state == IDLE) || (state == PARITY);
`else
    ready_slot = (state == IDLE) || last_bit;
`endif
  end

  assign din_ready = ready_slot && !rst;
  assign accept    = din_valid && din_ready;

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = SHIFT;
      end
      SHIFT: begin
        if (cnt == '0) begin
`ifdef PARITY_EN
          state_next = PARITY;
`else
          state_next = accept ? SHIFT : IDLE;
`endif
        end
      end
      PARITY: begin
        state_next = accept ? SHIFT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath: load on accept, otherwise shift left until the counter reaches zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
      fs_q <= 1'b0;
    end else begin
      fs_q <= accept;
      if (accept) begin
        sreg <= din;
        cnt  <= CW'(WIDTH - 1);
      end else if ((state == SHIFT) && (cnt != '0)) begin
        sreg <= sreg << 1;
        cnt  <= cnt - CW'(1);
      end
    end
  end

`ifdef PARITY_EN
  // Even parity of the word captured at load time, emitted in the PARITY cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         par_q <= 1'b0;
    else if (accept) par_q <= ^din;
  end
`endif

  // Output decode: zeros between frames so the detector sees a quiet line.
  always_comb begin
    bit_out = 1'b0;
    case (state)
      SHIFT:   bit_out = sreg[WIDTH-1];
`ifdef PARITY_EN
      PARITY:  bit_out = par_q;
`endif
      default: bit_out = 1'b0;
    endcase
  end

  assign bit_valid   = (state != IDLE);
  assign busy        = (state != IDLE);
  assign frame_start = fs_q;

endmodule
